// File: rtl/fft_modulus_pkg.sv
// Shared widths, mode constants and latency helper for the FFT bin magnitude unit.
package fft_modulus_pkg;

    localparam int MODE_MAG = 0;
    localparam int MODE_POW = 1;

    function automatic int sq_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int out_w(input int dw, input int mode);
        return (mode == MODE_POW) ? 2 * dw : dw;
    endfunction

    function automatic int lat(input int dw);
        return 3 + dw;
    endfunction

endpackage

// File: rtl/fft_modulus_isqrt_pipe.sv
// Fully pipelined non-restoring integer square root, one root bit per stage,
// with valid/sop/eop tags carried alongside each stage.
module isqrt_pipe #(
    parameter int  IN_W = 18,
    localparam int RW   = IN_W / 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] rad_i,
    input  logic            vld_i,
    input  logic            sop_i,
    input  logic            eop_i,
    output logic [RW-1:0]   root_o,
    output logic            vld_o,
    output logic            sop_o,
    output logic            eop_o
);

    // Signed partial remainder stays within RW+3 magnitude bits, one spare for sign.
    localparam int RMW = RW + 4;

    logic [IN_W-1:0] rad_q  [RW];
    logic [RMW-1:0]  rem_q  [RW];
    logic [RW-1:0]   root_q [RW];
    logic            vld_q  [RW];
    logic            sop_q  [RW];
    logic            eop_q  [RW];

    for (genvar gi = 0; gi < RW; gi++) begin : g_stage
        logic [IN_W-1:0] rad_in;
        logic [RMW-1:0]  rem_in;
        logic [RW-1:0]   root_in;
        logic            vld_in;
        logic            sop_in;
        logic            eop_in;
        logic [RMW-1:0]  shifted;
        logic [RMW-1:0]  trial;
        logic [RMW-1:0]  rem_d;
        logic [RW-1:0]   root_d;
        logic [IN_W-1:0] rad_d;

        if (gi == 0) begin : g_head
            assign rad_in  = rad_i;
            assign rem_in  = '0;
            assign root_in = '0;
            assign vld_in  = vld_i;
            assign sop_in  = sop_i;
            assign eop_in  = eop_i;
        end else begin : g_tail
            assign rad_in  = rad_q[gi-1];
            assign rem_in  = rem_q[gi-1];
            assign root_in = root_q[gi-1];
            assign vld_in  = vld_q[gi-1];
            assign sop_in  = sop_q[gi-1];
            assign eop_in  = eop_q[gi-1];
        end

        // A negative remainder is corrected by adding next stage's trial, not restored.
        always_comb begin
            shifted = (rem_in << 2) | RMW'(rad_in[IN_W-1 -: 2]);
            trial   = {2'b00, root_in, (rem_in[RMW-1] ? 2'b11 : 2'b01)};
            rem_d   = rem_in[RMW-1] ? (shifted + trial) : (shifted - trial);
            root_d  = {root_in[RW-2:0], ~rem_d[RMW-1]};
            rad_d   = rad_in << 2;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rad_q[gi]  <= '0;
                rem_q[gi]  <= '0;
                root_q[gi] <= '0;
                vld_q[gi]  <= 1'b0;
                sop_q[gi]  <= 1'b0;
                eop_q[gi]  <= 1'b0;
            end else begin
                rad_q[gi]  <= rad_d;
                rem_q[gi]  <= rem_d;
                root_q[gi] <= root_d;
                vld_q[gi]  <= vld_in;
                sop_q[gi]  <= sop_in;
                eop_q[gi]  <= eop_in;
            end
        end
    end

    assign root_o = root_q[RW-1];
    assign vld_o  = vld_q[RW-1];
    assign sop_o  = sop_q[RW-1];
    assign eop_o  = eop_q[RW-1];

endmodule

// File: rtl/fft_modulus.sv
// FFT bin magnitude/power unit with frame tags and bin index; the per-frame
// peak tracker is built only when FFT_MODULUS_PEAK_EN is defined.
module fft_modulus
    import fft_modulus_pkg::*;
#(
    parameter int  DW    = 9,
    parameter int  MODE  = MODE_MAG,
    parameter int  BIN_W = 10,
    localparam int SQ_W  = sq_w(DW),
    localparam int OW    = out_w(DW, MODE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] source_real,
    input  logic signed [DW-1:0] source_imag,
    input  logic                 source_valid,
    input  logic                 source_eop,
    output logic [OW-1:0]        data_out,
    output logic                 data_valid,
    output logic                 data_sop,
    output logic                 data_eop,
    output logic [BIN_W-1:0]     data_bin,
    output logic [OW-1:0]        peak_value,
    output logic [BIN_W-1:0]     peak_bin,
    output logic                 peak_valid
);

    logic             first_q, first_d;
    logic [DW-1:0]    re_abs_q, re_abs_d, im_abs_q, im_abs_d;
    logic             s1_vld_q, s1_vld_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic [SQ_W-2:0]  re_sq_q, re_sq_d, im_sq_q, im_sq_d;
    logic             s2_vld_q, s2_sop_q, s2_eop_q;
    logic [SQ_W-1:0]  sum_q, sum_d;
    logic             s3_vld_q, s3_sop_q, s3_eop_q;
    logic [BIN_W-1:0] s3_bin_q, s3_bin_d;
    logic [BIN_W-1:0] bin_q [DW];

    // Magnitude of -2^(DW-1) is 2^(DW-1), which still fits DW unsigned bits.
    always_comb begin
        re_abs_d = source_real[DW-1] ? (~source_real + DW'(1)) : source_real;
        im_abs_d = source_imag[DW-1] ? (~source_imag + DW'(1)) : source_imag;
        s1_vld_d = source_valid;
        s1_sop_d = source_valid & first_q;
        s1_eop_d = source_valid & source_eop;
        first_d  = source_valid ? source_eop : first_q;
        re_sq_d  = (SQ_W-1)'(SQ_W'(re_abs_q) * SQ_W'(re_abs_q));
        im_sq_d  = (SQ_W-1)'(SQ_W'(im_abs_q) * SQ_W'(im_abs_q));
        sum_d    = SQ_W'(re_sq_q) + SQ_W'(im_sq_q);
        s3_bin_d = s3_bin_q;
        if (s2_vld_q) begin
            s3_bin_d = s2_sop_q ? '0 : s3_bin_q + BIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q  <= 1'b1;
            re_abs_q <= '0;
            im_abs_q <= '0;
            s1_vld_q <= 1'b0;
            s1_sop_q <= 1'b0;
            s1_eop_q <= 1'b0;
            re_sq_q  <= '0;
            im_sq_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_sop_q <= 1'b0;
            s2_eop_q <= 1'b0;
            sum_q    <= '0;
            s3_vld_q <= 1'b0;
            s3_sop_q <= 1'b0;
            s3_eop_q <= 1'b0;
            s3_bin_q <= '0;
        end else begin
            first_q  <= first_d;
            re_abs_q <= re_abs_d;
            im_abs_q <= im_abs_d;
            s1_vld_q <= s1_vld_d;
            s1_sop_q <= s1_sop_d;
            s1_eop_q <= s1_eop_d;
            re_sq_q  <= re_sq_d;
            im_sq_q  <= im_sq_d;
            s2_vld_q <= s1_vld_q;
            s2_sop_q <= s1_sop_q;
            s2_eop_q <= s1_eop_q;
            sum_q    <= sum_d;
            s3_vld_q <= s2_vld_q;
            s3_sop_q <= s2_sop_q;
            s3_eop_q <= s2_eop_q;
            s3_bin_q <= s3_bin_d;
        end
    end

    // Bin index is assigned at the sum stage and rides beside the root stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DW; i++) bin_q[i] <= '0;
        end else begin
            bin_q[0] <= s3_bin_q;
            for (int i = 1; i < DW; i++) bin_q[i] <= bin_q[i-1];
        end
    end

    assign data_bin = bin_q[DW-1];

    if (MODE == MODE_MAG) begin : g_mag
        isqrt_pipe #(
            .IN_W (SQ_W)
        ) u_isqrt (
            .clk    (clk),
            .rst    (rst),
            .rad_i  (sum_q),
            .vld_i  (s3_vld_q),
            .sop_i  (s3_sop_q),
            .eop_i  (s3_eop_q),
            .root_o (data_out),
            .vld_o  (data_valid),
            .sop_o  (data_sop),
            .eop_o  (data_eop)
        );
    end else begin : g_pow
        logic [SQ_W-1:0] pow_q [DW];
        logic            pvld_q [DW];
        logic            psop_q [DW];
        logic            peop_q [DW];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DW; i++) begin
                    pow_q[i]  <= '0;
                    pvld_q[i] <= 1'b0;
                    psop_q[i] <= 1'b0;
                    peop_q[i] <= 1'b0;
                end
            end else begin
                pow_q[0]  <= sum_q;
                pvld_q[0] <= s3_vld_q;
                psop_q[0] <= s3_sop_q;
                peop_q[0] <= s3_eop_q;
                for (int i = 1; i < DW; i++) begin
                    pow_q[i]  <= pow_q[i-1];
                    pvld_q[i] <= pvld_q[i-1];
                    psop_q[i] <= psop_q[i-1];
                    peop_q[i] <= peop_q[i-1];
                end
            end
        end

        assign data_out   = pow_q[DW-1];
        assign data_valid = pvld_q[DW-1];
        assign data_sop   = psop_q[DW-1];
        assign data_eop   = peop_q[DW-1];
    end

`ifdef FFT_MODULUS_PEAK_EN
    logic [OW-1:0]    run_max_q, run_max_d, peak_value_q, peak_value_d;
    logic [BIN_W-1:0] run_bin_q, run_bin_d, peak_bin_q, peak_bin_d;
    logic             peak_valid_q, peak_valid_d;

    // Strict greater-than keeps the lowest bin on ties; sop restarts the running max.
    always_comb begin
        run_max_d    = run_max_q;
        run_bin_d    = run_bin_q;
        peak_value_d = peak_value_q;
        peak_bin_d   = peak_bin_q;
        peak_valid_d = 1'b0;
        if (data_valid) begin
            if (data_sop || (data_out > run_max_q)) begin
                run_max_d = data_out;
                run_bin_d = data_bin;
            end
            if (data_eop) begin
                peak_value_d = run_max_d;
                peak_bin_d   = run_bin_d;
                peak_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_q    <= '0;
            run_bin_q    <= '0;
            peak_value_q <= '0;
            peak_bin_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            run_max_q    <= run_max_d;
            run_bin_q    <= run_bin_d;
            peak_value_q <= peak_value_d;
            peak_bin_q   <= peak_bin_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_value = peak_value_q;
    assign peak_bin   = peak_bin_q;
    assign peak_valid = peak_valid_q;
`else
    assign peak_value = '0;
    assign peak_bin   = '0;
    assign peak_valid = 1'b0;
`endif

endmodule
